// File: rtl/varredura_display.sv
// Two-digit sign/magnitude scanner with dead time and frame-aligned updates.
// Optional macro VARREDURA_OVF_EN shows an error glyph on adder overflow.
module varredura_display #(
  parameter int DIV = 50000,
  parameter int GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] valor,
  input  logic       ovf,
  input  logic       carga,
  output logic [3:0] bcd,
  output logic [1:0] anodo,
  output logic       quadro
);

  localparam int MAXL = (DIV > GAP) ? DIV : GAP;
  localparam int CW   = $clog2(MAXL + 1);

`ifdef VARREDURA_OVF_EN
  localparam int VW = 5;
`else
  localparam int VW = 4;
`endif

  typedef enum logic [1:0] {
    S_SINAL,
    G1,
    S_MAG,
    G2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]   pend_q, pend_d;
  logic [VW-1:0]   shd_q, shd_d;
  logic [3:0]      bcd_q, bcd_d;
  logic [1:0]      anodo_q, anodo_d;
  logic            quadro_q, quadro_d;
  logic            frame_start;
  logic [3:0]      sign_c, mag_c, val_c;

`ifdef VARREDURA_OVF_EN
  assign pend_d = carga ? {ovf, valor} : pend_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
  assign pend_d = carga ? valor : pend_q;
`endif

  // Next cycle begins a new frame: shadow must reflect the old pending value.
  assign frame_start = (state_q == G2) && (cnt_q == '0);
  assign shd_d = frame_start ? pend_q : shd_q;
  assign val_c = shd_d[3:0];

  always_comb begin
    sign_c = 4'hF;
    mag_c  = val_c;
    if (val_c[3]) begin
      sign_c = 4'hA;
      mag_c  = ~val_c + 4'd1;
    end
`ifdef VARREDURA_OVF_EN
    if (shd_d[4]) begin
      sign_c = 4'hE;
      mag_c  = 4'hE;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    if (cnt_q == '0) begin
      unique case (state_q)
        S_SINAL: begin
          state_d = G1;
          cnt_d   = CW'(GAP - 1);
        end
        G1: begin
          state_d = S_MAG;
          cnt_d   = CW'(DIV - 1);
        end
        S_MAG: begin
          state_d = G2;
          cnt_d   = CW'(GAP - 1);
        end
        G2: begin
          state_d = S_SINAL;
          cnt_d   = CW'(DIV - 1);
        end
        default: begin
          state_d = G2;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    anodo_d  = 2'b11;
    bcd_d    = 4'hF;
    quadro_d = frame_start;
    unique case (state_d)
      S_SINAL: begin
        anodo_d = 2'b10;
        bcd_d   = sign_c;
      end
      S_MAG: begin
        anodo_d = 2'b01;
        bcd_d   = mag_c;
      end
      default: begin
        anodo_d = 2'b11;
        bcd_d   = 4'hF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= G2;
      cnt_q    <= '0;
      pend_q   <= '0;
      shd_q    <= '0;
      bcd_q    <= 4'hF;
      anodo_q  <= 2'b11;
      quadro_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      shd_q    <= shd_d;
      bcd_q    <= bcd_d;
      anodo_q  <= anodo_d;
      quadro_q <= quadro_d;
    end
  end

  assign bcd    = bcd_q;
  assign anodo  = anodo_q;
  assign quadro = quadro_q;

endmodule
